alu_mul_sequencer: RTL and testbench

Multi-cycle initiator that drives the combinational 8-bit ALU through its operand/op interface to compute an 8x8 multiply (low 8 bits of the product) by shift-and-add. The block takes a request over a valid/ready handshake and issues one ALU operation per cycle. It uses ANDB for partial products, ADD for accumulation, and SHIFT for operand stepping. It captures alu_out each cycle and returns the product over a valid/ready response handshake. It sits between the core's multi-cycle control path and an ALU instance; it owns the ALU inputs whenever it is busy.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings and the multiply sequencer state type.
package alu_pkg;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_ANDB  = 2'b01;
    localparam logic [1:0] ALU_XOR   = 2'b10;
    localparam logic [1:0] ALU_SHIFT = 2'b11;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ANDB,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows an external combinational ALU,
// issuing one ANDB/ADD/SHIFT operation per cycle while busy.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_prod,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [1:0]       alu_op,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int ITER_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    seq_state_e        state, next_state;
    logic [WIDTH-1:0]  a_r, b_r, acc_r, pp_r;
    logic [ITER_W-1:0] iter_r;
    logic              last_iter;

    assign last_iter  = (iter_r == ITER_W'(WIDTH - 1));
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_DONE);
    assign resp_prod  = acc_r;

    // ALU drive depends only on registered state, so req_valid and
    // resp_ready never reach the ALU inputs combinationally.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state = state;
        alu_in1    = '0;
        alu_in2    = '0;
        alu_op     = ALU_ADD;
        alu_sub    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_valid)
                    next_state = (EARLY_EXIT && req_b == '0) ? S_DONE : S_ANDB;
            end
            S_ANDB: begin
                alu_in1    = a_r;
                alu_in2    = b_r;
                alu_op     = ALU_ANDB;
                next_state = S_ADD;
            end
            S_ADD: begin
                alu_in1    = acc_r;
                alu_in2    = pp_r;
                next_state = S_SHL;
            end
            S_SHL: begin
                alu_in1    = a_r;
                alu_in2    = WIDTH'(1);
                alu_op     = ALU_SHIFT;
                alu_sub    = SHIFT_LEFT;
                next_state = S_SHR;
            end
            S_SHR: begin
                alu_in1 = b_r;
                alu_in2 = WIDTH'(1);
                alu_op  = ALU_SHIFT;
                alu_sub = SHIFT_RIGHT;
                if (last_iter || (EARLY_EXIT && alu_out == '0))
                    next_state = S_DONE;
                else
                    next_state = S_ANDB;
            end
            S_DONE: begin
                if (resp_ready)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Datapath registers load from the request or capture alu_out for the
    // operation issued in the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r    <= '0;
            b_r    <= '0;
            acc_r  <= '0;
            pp_r   <= '0;
            iter_r <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_r    <= req_a;
                        b_r    <= req_b;
                        acc_r  <= '0;
                        iter_r <= '0;
                    end
                end
                S_ANDB: pp_r  <= alu_out;
                S_ADD:  acc_r <= alu_out;
                S_SHL:  a_r   <= alu_out;
                S_SHR: begin
                    b_r <= alu_out;
                    if (next_state == S_ANDB)
                        iter_r <= iter_r + ITER_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench: instance 0 runs with EARLY_EXIT=0, instance 1 with EARLY_EXIT=1,
// each driving its own behavioural ALU; products are checked through a scoreboard.
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset[2], req_valid[2], req_ready[2], resp_valid[2], resp_ready[2], alu_sub[2];
    logic [W-1:0] req_a[2], req_b[2], resp_prod[2], alu_in1[2], alu_in2[2], alu_out[2];
    logic [1:0]   alu_op[2];

    function automatic logic [W-1:0] alu_model(logic [W-1:0] in1, logic [W-1:0] in2,
                                               logic [1:0] op, logic sub);
        case (op)
            ALU_ADD:  return sub ? in1 - in2 : in1 + in2;
            ALU_ANDB: return in1 & {W{in2[0]}};
            ALU_XOR:  return in1 ^ in2;
            default:  return sub ? in1 >> in2 : in1 << in2;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_mul_sequencer #(.WIDTH(W), .EARLY_EXIT(g == 1 ? 1'b1 : 1'b0)) dut (
            .clk        (clk),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_a      (req_a[g]),
            .req_b      (req_b[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_prod  (resp_prod[g]),
            .alu_in1    (alu_in1[g]),
            .alu_in2    (alu_in2[g]),
            .alu_op     (alu_op[g]),
            .alu_sub    (alu_sub[g]),
            .alu_out    (alu_out[g])
        );
        assign alu_out[g] = alu_model(alu_in1[g], alu_in2[g], alu_op[g], alu_sub[g]);
    end

    typedef struct {
        logic [W-1:0] prod;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Latency counts clock edges after the accept edge; a zero multiplier
    // with early exit lands in DONE on the accept edge itself.
    function automatic int exp_latency(int idx, logic [W-1:0] b);
        int top;
        if (idx == 0) return 4 * W;
        if (b == '0) return 0;
        top = 0;
        for (int i = 0; i < W; i++)
            if (b[i]) top = i;
        return 4 * (top + 1);
    endfunction

    task automatic push_exp(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.prod = W'(a * b);
        e.lat  = exp_latency(idx, b);
        sb.push_back(e);
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge after accept.
    task automatic send_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        check($sformatf("req_ready_idle%0d", idx), req_ready[idx], 1);
        req_valid[idx] = 1'b1;
        req_a[idx]     = a;
        req_b[idx]     = b;
        push_exp(idx, a, b);
        @(negedge clk);
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_resp(input int idx, input int start_lat);
        int   lat;
        logic seen_ready;
        exp_t e;
        lat        = start_lat;
        seen_ready = 1'b0;
        while (!resp_valid[idx] && lat < 200) begin
            seen_ready |= req_ready[idx];
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check($sformatf("req_ready_busy%0d", idx), seen_ready, 0);
        check($sformatf("latency%0d", idx), lat, e.lat);
        check($sformatf("prod%0d", idx), resp_prod[idx], e.prod);
    endtask

    task automatic finish_resp(input int idx);
        resp_ready[idx] = 1'b1;
        @(negedge clk);
        check($sformatf("resp_valid_low%0d", idx), resp_valid[idx], 0);
        check($sformatf("req_ready_back%0d", idx), req_ready[idx], 1);
    endtask

    task automatic check_idle_outputs(input int idx);
        check($sformatf("rst_req_ready%0d", idx), req_ready[idx], 1);
        check($sformatf("rst_resp_valid%0d", idx), resp_valid[idx], 0);
        check($sformatf("rst_resp_prod%0d", idx), resp_prod[idx], 0);
        check($sformatf("rst_alu_in1_%0d", idx), alu_in1[idx], 0);
        check($sformatf("rst_alu_in2_%0d", idx), alu_in2[idx], 0);
        check($sformatf("rst_alu_op%0d", idx), alu_op[idx], 0);
        check($sformatf("rst_alu_sub%0d", idx), alu_sub[idx], 0);
    endtask

    logic [1:0] op_seq[4];

    initial begin
        op_seq = '{ALU_ANDB, ALU_ADD, ALU_SHIFT, ALU_SHIFT};
        for (int i = 0; i < 2; i++) begin
            reset[i]      = 1'b1;
            req_valid[i]  = 1'b0;
            req_a[i]      = '0;
            req_b[i]      = '0;
            resp_ready[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        @(negedge clk);
        check_idle_outputs(0);
        check_idle_outputs(1);

        // Fixed-latency instance: ordinary, full-wrap and zero-wrap products.
        send_req(0, 8'd3, 8'd5);
        wait_resp(0, 0);
        finish_resp(0);
        send_req(0, 8'hFF, 8'hFF);
        wait_resp(0, 0);
        finish_resp(0);
        send_req(0, 8'h10, 8'h10);
        wait_resp(0, 0);
        finish_resp(0);

        // Early-exit instance: short multiplier and zero multiplier.
        send_req(1, 8'd3, 8'd5);
        wait_resp(1, 0);
        finish_resp(1);
        send_req(1, 8'h5C, 8'h00);
        wait_resp(1, 0);
        finish_resp(1);

        // Operation trace for 7*3 with the response held off.
        resp_ready[1] = 1'b0;
        send_req(1, 8'd7, 8'd3);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("trace_op%0d", c), alu_op[1], op_seq[c % 4]);
            if (c % 4 == 1)
                check($sformatf("trace_pp%0d", c / 4), g_dut[1].dut.pp_r,
                      (c / 4 == 0) ? 8'h07 : 8'h0E);
            @(negedge clk);
        end
        wait_resp(1, 8);

        // Backpressure: DONE holds and a pending request is ignored.
        req_valid[1] = 1'b1;
        req_a[1]     = 8'd2;
        req_b[1]     = 8'd9;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_valid", resp_valid[1], 1);
            check("hold_prod", resp_prod[1], 8'h15);
            check("hold_ready", req_ready[1], 0);
        end
        resp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", req_ready[1], 1);
        check("bp_idle_valid", resp_valid[1], 0);
        push_exp(1, 8'd2, 8'd9);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("bp_accepted", req_ready[1], 0);
        wait_resp(1, 0);
        finish_resp(1);

        // Reset in cycle 10 of an operation, then a fresh request.
        send_req(0, 8'h5A, 8'h77);
        sb.delete();
        repeat (9) @(negedge clk);
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        check("rst_state", g_dut[0].dut.state, S_IDLE);
        check_idle_outputs(0);
        send_req(0, 8'd2, 8'd9);
        wait_resp(0, 0);
        finish_resp(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
